// File: rtl/axi4lite_regfile_if.sv
// AXI4-Lite channel bundle shared by a host (master) and a register endpoint (slave).
interface axi4lite_intf #(
    parameter int AXI4L_ADDR_WIDTH = 32,
    parameter int AXI4L_DATA_WIDTH = 32
);
    logic [AXI4L_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                    awprot;
    logic                          awvalid;
    logic                          awready;
    logic [AXI4L_DATA_WIDTH-1:0]   wdata;
    logic [AXI4L_DATA_WIDTH/8-1:0] wstrb;
    logic                          wvalid;
    logic                          wready;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [AXI4L_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                    arprot;
    logic                          arvalid;
    logic                          arready;
    logic [AXI4L_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                    rresp;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_regfile.sv
// AXI4-Lite register bank: NUM_REGS words at BASE_ADDR, RW or RO (status) per
// register, byte-strobe writes, SLVERR on RO writes, DECERR outside the window.
// Optional build macro AXI4L_REGFILE_PROT_CHECK_EN: rejects unprivileged
// accesses (prot[0]=0) with SLVERR; DECERR still wins for out-of-range.
module axi4lite_regfile #(
    parameter int                             ADDR_W    = 32,
    parameter int                             DATA_W    = 32,
    parameter int                             NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0]              BASE_ADDR = {ADDR_W{1'b0}},
    parameter logic [NUM_REGS-1:0]            RO_MASK   = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL = {(NUM_REGS*DATA_W){1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axi4lite_intf.slave                  s_axil,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);

    typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } wstate_t;
    typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } rstate_t;

    // Word index of an address relative to the window base (low byte bits dropped).
    function automatic logic [ADDR_W-1:0] f_index(input logic [ADDR_W-1:0] addr);
        return (addr - BASE_ADDR) >> LSB;
    endfunction

    // Address falls inside the register window.
    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        return (addr >= BASE_ADDR) && (f_index(addr) < ADDR_W'(NUM_REGS));
    endfunction

    wstate_t             r_wstate;
    logic                r_aw_held;
    logic                r_w_held;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    rstate_t             r_rstate;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;

    logic                w_aw_fire, w_w_fire, w_commit, w_ar_fire;
    logic [ADDR_W-1:0]   w_awaddr, w_widx, w_ridx;
    logic [DATA_W-1:0]   w_wdata, w_rword;
    logic [STRB_W-1:0]   w_wstrb;
    logic                w_win, w_wro, w_rin, w_rro, w_wprot_ok, w_rprot_ok, w_wapply;
    logic [1:0]          w_wresp;
    logic [NUM_REGS-1:0] w_pulse;

    assign s_axil.awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign s_axil.wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.arready = (r_rstate == R_IDLE);
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = r_rresp;
    assign wr_pulse       = r_wr_pulse;

    assign w_aw_fire = s_axil.awvalid && s_axil.awready;
    assign w_w_fire  = s_axil.wvalid && s_axil.wready;
    // Commit on the edge where both halves are (or become) held.
    assign w_commit  = (r_wstate == W_IDLE) && (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
    assign w_awaddr  = r_aw_held ? r_awaddr : s_axil.awaddr;
    assign w_wdata   = r_w_held  ? r_wdata  : s_axil.wdata;
    assign w_wstrb   = r_w_held  ? r_wstrb  : s_axil.wstrb;
    assign w_widx    = f_index(w_awaddr);
    assign w_win     = f_in_range(w_awaddr);
    assign w_ar_fire = s_axil.arvalid && (r_rstate == R_IDLE);
    assign w_ridx    = f_index(s_axil.araddr);
    assign w_rin     = f_in_range(s_axil.araddr);

`ifdef AXI4L_REGFILE_PROT_CHECK_EN
    logic r_awprot0;

    // Hold the privilege bit of an address phase that arrived before its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awprot0 <= 1'b0;
        end else if (w_aw_fire) begin
            r_awprot0 <= s_axil.awprot[0];
        end
    end

    assign w_wprot_ok = r_aw_held ? r_awprot0 : s_axil.awprot[0];
    assign w_rprot_ok = s_axil.arprot[0];
`else
    assign w_wprot_ok = 1'b1;
    assign w_rprot_ok = 1'b1;
`endif

    // Decode write target: read-only flag, response code and per-register strobe.
    always_comb begin
        w_wro   = 1'b0;
        w_pulse = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wro = w_wro | (RO_MASK[i] & (w_widx == ADDR_W'(i)));
        end
        if (!w_win) begin
            w_wresp = 2'b11;
        end else if (w_wro || !w_wprot_ok) begin
            w_wresp = 2'b10;
        end else begin
            w_wresp = 2'b00;
        end
        w_wapply = w_commit && w_win && !w_wro && w_wprot_ok;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pulse[i] = w_wapply && (w_widx == ADDR_W'(i));
        end
    end

    // Read mux: RW registers return stored value, RO registers return status input.
    always_comb begin
        w_rro   = 1'b0;
        w_rword = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rro   = w_rro | (RO_MASK[i] & (w_ridx == ADDR_W'(i)));
            w_rword = w_rword | ({DATA_W{w_ridx == ADDR_W'(i)}} &
                      (RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : r_regs[i]));
        end
    end

    // Register storage with byte-lane updates and the one-cycle write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_pulse <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RO_MASK[i] ? {DATA_W{1'b0}} : RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            r_wr_pulse <= w_pulse;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_pulse[i] && w_wstrb[b]) begin
                        r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Write channel FSM: capture AW/W independently, commit, hold B until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= {ADDR_W{1'b0}};
            r_wdata   <= {DATA_W{1'b0}};
            r_wstrb   <= {STRB_W{1'b0}};
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_fire) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s_axil.awaddr;
                    end
                    if (w_w_fire) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s_axil.wdata;
                        r_wstrb  <= s_axil.wstrb;
                    end
                    if (w_commit) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wresp;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_bvalid  <= 1'b0;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: register the response on AR, hold it until R is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= {DATA_W{1'b0}};
            r_rresp  <= 2'b00;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                        if (!w_rin) begin
                            r_rdata <= {DATA_W{1'b0}};
                            r_rresp <= 2'b11;
                        end else if (!w_rprot_ok) begin
                            r_rdata <= {DATA_W{1'b0}};
                            r_rresp <= 2'b10;
                        end else begin
                            r_rdata <= w_rword;
                            r_rresp <= 2'b00;
                        end
                    end
                end
                R_DATA: begin
                    if (s_axil.rready) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    // Flatten register array onto the output bus (RO slots are held at zero).
    always_comb begin
        reg_out = {(NUM_REGS*DATA_W){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = r_regs[i];
        end
    end

    // w_rro is only informative for the read path; keep it observable in the mux.
    logic w_unused_s;
    assign w_unused_s = w_rro;
endmodule

// File: tb/tb_axi4lite_regfile.sv
// Scoreboard bench for axi4lite_regfile: expected B/R responses are queued at
// issue time and compared by an independent monitor on each handshake.
module tb_axi4lite_regfile;
    localparam logic [31:0]  BASE = 32'h0000_1000;
    localparam logic [15:0]  ROM  = 16'h0008;
    localparam logic [511:0] RV   = 512'h1111_1111 << 32;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] reg_out;
    logic [511:0] reg_in;
    logic [15:0]  wr_pulse;
    logic [31:0]  mdl [16];
    logic [1:0]   exp_b_q [$];
    rexp_t        exp_r_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    axi4lite_intf #(.AXI4L_ADDR_WIDTH(32), .AXI4L_DATA_WIDTH(32)) bus ();

    axi4lite_regfile #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(16),
        .BASE_ADDR(BASE), .RO_MASK(ROM), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axil(bus),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        for (int i = 0; i < 16; i++) begin
            chk(name, {32'(i), reg_out[i*32 +: 32]}, {32'(i), mdl[i]});
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        mdl[1] = 32'h1111_1111;
    endtask

    // Monitor: pop and compare on every B and R handshake.
    always @(negedge clk) begin
        if (rst_n && bus.bvalid && bus.bready) begin
            chk("b_expected", 64'(exp_b_q.size() != 0), 64'd1);
            if (exp_b_q.size() != 0) chk("bresp", 64'(bus.bresp), 64'(exp_b_q.pop_front()));
        end
        if (rst_n && bus.rvalid && bus.rready) begin
            chk("r_expected", 64'(exp_r_q.size() != 0), 64'd1);
            if (exp_r_q.size() != 0) begin
                rexp_t e;
                e = exp_r_q.pop_front();
                chk("rdata_rresp", {30'd0, bus.rdata, bus.rresp}, {30'd0, e.data, e.resp});
            end
        end
    end

    // Each send task starts just after a rising edge and returns just after the accepting edge.
    task automatic send_aw(input logic [31:0] a);
        logic ok = 1'b0;
        bus.awaddr = a; bus.awvalid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk); ok = bus.awready;
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0;
        if (!ok) chk("aw_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        logic ok = 1'b0;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk); ok = bus.wready;
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        if (!ok) chk("w_timeout", 64'd1, 64'd0);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er);
        logic aok = 1'b0, wok = 1'b0;
        exp_b_q.push_back(er);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int c = 0; c < 20 && !(aok && wok); c++) begin
            @(negedge clk);
            if (bus.awvalid && bus.awready) aok = 1'b1;
            if (bus.wvalid && bus.wready) wok = 1'b1;
            @(posedge clk); #1;
            if (aok) bus.awvalid = 1'b0;
            if (wok) bus.wvalid = 1'b0;
        end
        if (!(aok && wok)) chk("write_timeout", 64'd1, 64'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        logic ok = 1'b0;
        rexp_t e;
        e.data = ed; e.resp = er;
        exp_r_q.push_back(e);
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk); ok = bus.arready;
            @(posedge clk); #1;
        end
        bus.arvalid = 1'b0;
        if (!ok) chk("read_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.awaddr = 32'h0; bus.awprot = 3'b001; bus.awvalid = 1'b0;
        bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = 32'h0; bus.arprot = 3'b001; bus.arvalid = 1'b0; bus.rready = 1'b1;
        reg_in = 512'h0;
        reg_in[2*32 +: 32] = 32'hBAD0_BAD0;
        reg_in[3*32 +: 32] = 32'h0000_0055;
        mdl_reset();
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        // Reset state: ready high, no responses, zero payloads, reset values.
        chk("reset_ctrl", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, 16'(wr_pulse)},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0});
        chk("reset_payload", {bus.bresp, bus.rresp, bus.rdata}, {2'b00, 2'b00, 32'h0});
        chk_regs("reset_regs");
        @(posedge clk); #1;

        // Write then read, same-edge AW/W; one-cycle latency and single-cycle pulse.
        axi_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 2'b00);
        mdl[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr1_bvalid_pulse", {bus.bvalid, 16'(wr_pulse)}, {1'b1, 16'h0004});
        chk("wr1_reg2", reg_out[2*32 +: 32], 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr1_pulse_off", {bus.bvalid, 16'(wr_pulse)}, {1'b0, 16'h0000});
        @(posedge clk); #1;
        axi_read(BASE + 32'h8, 32'hDEAD_BEEF, 2'b00);
        @(negedge clk);
        chk("rd1_rvalid_latency", bus.rvalid, 1'b1);
        idle(1);

        // W two cycles ahead of AW, partial strobe.
        axi_write(BASE + 32'h10, 32'hAAAA_AAAA, 4'hF, 2'b00);
        mdl[4] = 32'hAAAA_AAAA;
        idle(2);
        exp_b_q.push_back(2'b00);
        send_w(32'h1234_5678, 4'h3);
        @(negedge clk);
        chk("w_early_no_bvalid", bus.bvalid, 1'b0);
        @(posedge clk); #1;
        send_aw(BASE + 32'h10);
        mdl[4] = 32'hAAAA_5678;
        @(negedge clk);
        chk("w_early_bvalid", {bus.bvalid, 16'(wr_pulse)}, {1'b1, 16'h0010});
        chk("w_early_reg4", reg_out[4*32 +: 32], 32'hAAAA_5678);
        idle(2);
        axi_read(BASE + 32'h10, 32'hAAAA_5678, 2'b00);
        idle(2);

        // Read-only register: write rejected, read returns status input.
        axi_write(BASE + 32'hC, 32'h0000_00FF, 4'hF, 2'b10);
        @(negedge clk);
        chk("ro_no_pulse", {bus.bvalid, 16'(wr_pulse)}, {1'b1, 16'h0000});
        idle(2);
        axi_read(BASE + 32'hC, 32'h0000_0055, 2'b00);
        idle(2);
        axi_read(BASE + 32'h8, 32'hDEAD_BEEF, 2'b00);
        idle(2);

        // Out of range above the window and below the base; last register in range.
        axi_write(BASE + 32'h40, 32'h9999_9999, 4'hF, 2'b11);
        @(negedge clk);
        chk("oor_hi_no_pulse", 16'(wr_pulse), 16'h0);
        idle(2);
        axi_write(BASE - 32'h4, 32'h7777_7777, 4'hF, 2'b11);
        @(negedge clk);
        chk("oor_lo_no_pulse", 16'(wr_pulse), 16'h0);
        idle(2);
        axi_read(BASE + 32'h40, 32'h0, 2'b11);
        idle(2);
        axi_read(BASE - 32'h4, 32'h0, 2'b11);
        idle(2);
        axi_write(BASE + 32'h3C, 32'h0F0F_0F0F, 4'hF, 2'b00);
        mdl[15] = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("last_pulse", 16'(wr_pulse), 16'h8000);
        idle(2);
        axi_read(BASE + 32'h3F, 32'h0F0F_0F0F, 2'b00);
        idle(2);
        chk_regs("after_oor");

        // Backpressure: responses and payloads frozen, all readies low.
        bus.bready = 1'b0; bus.rready = 1'b0;
        axi_write(BASE + 32'h14, 32'hCAFE_F00D, 4'hF, 2'b00);
        mdl[5] = 32'hCAFE_F00D;
        axi_read(BASE + 32'h4, 32'h1111_1111, 2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("backpressure", {bus.bvalid, bus.bresp, bus.rvalid, bus.rdata, bus.rresp,
                                 bus.awready, bus.wready, bus.arready},
                {1'b1, 2'b00, 1'b1, 32'h1111_1111, 2'b00, 1'b0, 1'b0, 1'b0});
        end
        @(posedge clk); #1;
        bus.bready = 1'b1; bus.rready = 1'b1;
        idle(3);
        chk_regs("after_bp");

        // Reset while AW held and W pending: transaction dropped.
        send_aw(BASE + 32'h18);
        @(negedge clk);
        chk("aw_only_wready", {bus.awready, bus.wready, bus.bvalid}, {1'b0, 1'b1, 1'b0});
        rst_n = 1'b0;
        mdl_reset();
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, 16'(wr_pulse)},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0});
        chk("rst_mid_payload", {bus.bresp, bus.rresp, bus.rdata}, {2'b00, 2'b00, 32'h0});
        chk_regs("rst_mid_regs");
        @(posedge clk); #1;
        send_w(32'h5A5A_5A5A, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("w_alone_no_bvalid", {bus.bvalid, 16'(wr_pulse)}, {1'b0, 16'h0});
        end
        chk("reg6_untouched", reg_out[6*32 +: 32], 32'h0);
        chk("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
        chk("r_queue_drained", 64'(exp_r_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4lite_regfile.md
# axi4lite_regfile

Parametrised AXI4-Lite slave register bank: decodes a window of NUM_REGS word registers at BASE_ADDR, with per-register read-write or read-only (hardware status) behaviour, byte-strobe writes and AXI error responses. It connects through the `axi4lite_intf` slave modport and is the standard control/status endpoint behind the host AXI-Lite fabric. Data width, register count, base address, read-only map and reset values are all parameters.

## Interface
- ADDR_W, 32, AXI-Lite address width
- DATA_W, 32, data width; 32 or 64
- NUM_REGS, 16, number of registers, 1..256
- BASE_ADDR, 0, byte address of register 0; aligned to DATA_W/8
- RO_MASK, 0 (NUM_REGS bits), bit i = 1 makes register i read-only
- RESET_VAL, 0 (NUM_REGS*DATA_W bits), reset value of RW register i in slice i

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- s_axil  slave modport  axi4lite_intf.slave with AXI4L_ADDR_WIDTH=ADDR_W and AXI4L_DATA_WIDTH=DATA_W  host port
- reg_out  out  NUM_REGS*DATA_W  current RW register contents (RO slices drive 0)
- reg_in  in  NUM_REGS*DATA_W  status values returned on reads of RO registers
- wr_pulse  out  NUM_REGS  one-cycle strobe for register i on every committed write to it

## Operation
- Decode: off = addr - BASE_ADDR; idx = off >> log2(DATA_W/8); low byte-offset bits are ignored. The access is out of range if addr < BASE_ADDR or idx >= NUM_REGS.
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, awready = !aw_held and wready = !w_held. AW and W are captured independently, in either order or on the same edge.
  - On the edge where both AW and W are held, the write commits:
    - In range, RW register: byte lanes with wstrb=1 update; bresp=OKAY (00).
    - In range, RO register: no update; bresp=SLVERR (10).
    - Out of range: bresp=DECERR (11).
  - The commit moves the FSM to W_RESP with bvalid=1. The write strobes wr_pulse[idx] for any in-range write that is not rejected, including wstrb=0.
  - In W_RESP, awready=wready=0. bvalid holds until bready; the handshake edge returns to W_IDLE and clears the held flags.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE, arready=1. On arvalid, rdata is registered with one of: the RW register, the reg_in slice for an RO register, or 0 with rresp=DECERR if out of range. rresp=OKAY otherwise. The FSM moves to R_DATA with rvalid=1.
  - In R_DATA, arready=0. rvalid/rdata/rresp hold stable until rready, then the FSM returns to R_IDLE.
- Read and write channels are fully independent. A read accepted on the same edge as a write commit to the same register returns the pre-write value.
- awprot/arprot are ignored unless AXI4L_REGFILE_PROT_CHECK_EN is defined.

## Timing
- Reset (rst_n low, asynchronous):
  - Both FSMs go to IDLE; held flags clear.
  - awready=wready=arready=1 in the first cycle after reset deassertion.
  - bvalid=rvalid=0; bresp=rresp=00; rdata=0.
  - wr_pulse=0; RW registers take their RESET_VAL slice.
- Reset asserted mid-transaction aborts the transaction: the register keeps its pre-commit value if the commit edge has not occurred, and no response is issued.
- Write latency: AW+W accepted in cycle 0 gives bvalid in cycle 1, reg_out updated in cycle 1, and wr_pulse high in cycle 1 only.
- Read latency: AR accepted in cycle 0 gives rvalid in cycle 1.
- Throughput: one write per 2 cycles and one read per 2 cycles at best, with zero backpressure.
- Once valid is asserted, bvalid/rvalid and their payloads do not change before the handshake.

## Configuration
- AXI4L_REGFILE_PROT_CHECK_EN:
  - Defined: a write with awprot[0]=0 (unprivileged) to an in-range register is not applied, asserts no wr_pulse, and returns SLVERR. A read with arprot[0]=0 returns rdata=0 and SLVERR. Out-of-range accesses still return DECERR, which takes priority.
  - Undefined: prot bits are ignored and all accesses behave as in-range/out-of-range decode only.

## Test plan
- Write then read, default params: AW and W at 0x8 with data 0xDEADBEEF, wstrb=F → bresp=00 one cycle later and wr_pulse[2] high for 1 cycle. Read of 0x8 → 0xDEADBEEF, rresp=00.
- W two cycles before AW, wstrb=0x3, data 0x1234_5678, register previously 0xAAAA_AAAA → register = 0xAAAA_5678. bvalid rises the cycle after AW is accepted.
- RO_MASK bit 3 set, reg_in slice 3 = 0x55: write 0xFF to 0xC → SLVERR, no wr_pulse. Read 0xC → 0x55, OKAY.
- Access at 0x40 with NUM_REGS=16, plus access below a nonzero BASE_ADDR → DECERR on both write and read; rdata=0; no register changes.
- Backpressure: bready and rready held low for 5 cycles → bvalid, rvalid and payloads stable throughout, with awready, wready and arready held at 0.
- Assert rst_n low while AW is held but W is pending → all outputs at reset values. A subsequent W alone produces no bvalid.
